// File: rtl/counters_pkg.sv
// Shared constants and types for the counters engine front-end scheduler.
package counters_pkg;
   localparam int CH_Z0    = 0;
   localparam int CH_Y1    = 1;
   localparam int CH_X2    = 2;
   localparam int CH_W3    = 3;
   localparam int CH_DEBCT = 4;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam int TURN_W = 32;

   typedef logic [2:0]        chan_t;
   typedef logic [TURN_W-1:0] turn_t;
endpackage

// File: rtl/counters_ctl_rr_arb.sv
// Round-robin arbiter: one-hot grant among eligible requesters, search starts after the last winner.
module counters_ctl_rr_arb #(
   parameter int NREQ = 4
)(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [NREQ-1:0] elig_i,
   output logic [NREQ-1:0] grant_o
);
   localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [RW-1:0] rr_q, rr_d;
   logic          found;

   always_comb begin
      grant_o = '0;
      rr_d    = rr_q;
      found   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && elig_i[(int'(rr_q) + k) % NREQ]) begin
            found                                = 1'b1;
            grant_o[(int'(rr_q) + k) % NREQ]     = 1'b1;
            rr_d                                 = RW'((int'(rr_q) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rr_q <= '0;
      else          rr_q <= rr_d;
   end
endmodule

// File: rtl/counters_ctl.sv
// Scheduler/owner tracker for the counter channels: arbitration, load/tick/clear generation, completion.
// Optional per-channel completion statistics enabled by COUNTERS_CTL_STATS_EN.
module counters_ctl
   import counters_pkg::*;
#(
   parameter int NCH   = 5,
   parameter int NREQ  = 4,
   parameter int W     = 32,
   parameter int PRESC = 1
)(
   input  logic              sysclk,
   input  logic              foo_card_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*3-1:0] req_chan,
   input  logic [NREQ*W-1:0] req_turn,
   input  logic [NREQ-1:0]   req_bar,
   output logic              req_err,
   output logic [NCH-1:0]    ch_baz,
   output logic [W-1:0]      ch_turn,
   output logic [NCH-1:0]    ch_bar,
   output logic [NCH-1:0]    ch_blrb,
   output logic [NCH-1:0]    ch_zz1pb,
   input  logic [NCH-1:0]    ch_cwm,
   output logic [NCH-1:0]    done_chan,
   output logic [NREQ-1:0]   done_req,
   output logic [NCH-1:0]    busy
`ifdef COUNTERS_CTL_STATS_EN
   ,
   output logic [NCH*16-1:0] done_cnt
`endif
);
   localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

   chan_t           rchan [NREQ];
   logic [NREQ-1:0] rerr, elig, grant;
   logic [RW-1:0]   owner_q [NCH];
   logic [NCH-1:0]  busy_q, bar_q, baz_q, zz1pb_q, done_chan_q, cwm_q, rise;
   logic [NREQ-1:0] done_req_q, done_req_d;
   logic [W-1:0]    turn_q;
   logic            err_q;
   logic [PW-1:0]   pre_q;
   logic            strobe;

   chan_t           g_chan;
   logic [W-1:0]    g_turn;
   logic            g_bar, g_err, load;
   logic [RW-1:0]   g_idx;

   // Requests to a nonexistent channel are always eligible so they drain through the error path.
   always_comb begin
      for (int r = 0; r < NREQ; r++) begin
         rchan[r] = req_chan[r*3 +: 3];
         rerr[r]  = int'(rchan[r]) >= NCH;
         elig[r]  = req_valid[r] &
                    (rerr[r] | ~busy_q[rchan[r]] | (owner_q[rchan[r]] == RW'(r)));
      end
   end

   counters_ctl_rr_arb #(.NREQ(NREQ)) u_arb (
      .clk_i   (sysclk),
      .rst_n_i (foo_card_n),
      .elig_i  (elig),
      .grant_o (grant)
   );

   always_comb begin
      g_chan = '0;
      g_turn = '0;
      g_bar  = 1'b0;
      g_err  = 1'b0;
      g_idx  = '0;
      for (int r = 0; r < NREQ; r++) begin
         if (grant[r]) begin
            g_chan = rchan[r];
            g_turn = req_turn[r*W +: W];
            g_bar  = req_bar[r];
            g_err  = rerr[r];
            g_idx  = RW'(r);
         end
      end
   end

   assign load   = (|grant) & ~g_err;
   assign strobe = (pre_q == PW'(PRESC - 1));
   assign rise   = ch_cwm & ~cwm_q;

   always_comb begin
      done_req_d = '0;
      for (int c = 0; c < NCH; c++)
         if (rise[c] && busy_q[c]) done_req_d[owner_q[c]] = 1'b1;
   end

   always_ff @(posedge sysclk or negedge foo_card_n) begin
      if (!foo_card_n) begin
         pre_q       <= '0;
         cwm_q       <= '0;
         err_q       <= 1'b0;
         zz1pb_q     <= '1;
         done_chan_q <= '0;
         done_req_q  <= '0;
         baz_q       <= '0;
         bar_q       <= '0;
         busy_q      <= '0;
         turn_q      <= '0;
         for (int c = 0; c < NCH; c++) owner_q[c] <= '0;
      end else begin
         pre_q       <= strobe ? '0 : pre_q + 1'b1;
         cwm_q       <= ch_cwm;
         err_q       <= (|grant) & g_err;
         zz1pb_q     <= ~rise;
         done_chan_q <= rise & busy_q;
         done_req_q  <= done_req_d;
         baz_q       <= '0;
         for (int c = 0; c < NCH; c++)
            if (rise[c] && busy_q[c] && bar_q[c] == MODE_ONESHOT) busy_q[c] <= 1'b0;
         // A load on the same edge as a completion overrides the freed state.
         if (load) begin
            baz_q[g_chan]   <= 1'b1;
            turn_q          <= g_turn;
            bar_q[g_chan]   <= g_bar;
            busy_q[g_chan]  <= |g_turn;
            owner_q[g_chan] <= (|g_turn) ? g_idx : '0;
         end
      end
   end

   assign req_ready = grant;
   assign req_err   = err_q;
   assign ch_baz    = baz_q;
   assign ch_turn   = turn_q;
   assign ch_bar    = bar_q;
   assign ch_blrb   = {NCH{strobe}} & busy_q;
   assign ch_zz1pb  = zz1pb_q;
   assign done_chan = done_chan_q;
   assign done_req  = done_req_q;
   assign busy      = busy_q;

`ifdef COUNTERS_CTL_STATS_EN
   logic [15:0] cnt_q [NCH];

   always_ff @(posedge sysclk or negedge foo_card_n) begin
      if (!foo_card_n) begin
         for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (load && int'(g_chan) == c)
               cnt_q[c] <= '0;
            else if (rise[c] && busy_q[c] && cnt_q[c] != 16'hFFFF)
               cnt_q[c] <= cnt_q[c] + 16'd1;
         end
      end
   end

   always_comb begin
      done_cnt = '0;
      for (int c = 0; c < NCH; c++) done_cnt[c*16 +: 16] = cnt_q[c];
   end
`endif
endmodule

// File: tb/tb_counters_ctl.sv
// Directed bench for counters_ctl: a PRESC=1 instance and a PRESC=4 instance share the same stimulus.
module tb_counters_ctl;
   import counters_pkg::*;

   localparam int NCH  = 5;
   localparam int NREQ = 4;
   localparam int W    = 32;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*3-1:0] req_chan;
   logic [NREQ*W-1:0] req_turn;
   logic [NREQ-1:0]   req_bar;
   logic [NCH-1:0]    ch_cwm;

   logic [NREQ-1:0] req_ready, p_req_ready;
   logic            req_err, p_req_err;
   logic [NCH-1:0]  ch_baz, ch_bar, ch_blrb, ch_zz1pb, done_chan, busy;
   logic [NCH-1:0]  p_ch_baz, p_ch_bar, p_ch_blrb, p_ch_zz1pb, p_done_chan, p_busy;
   logic [W-1:0]    ch_turn, p_ch_turn;
   logic [NREQ-1:0] done_req, p_done_req;
`ifdef COUNTERS_CTL_STATS_EN
   logic [NCH*16-1:0] done_cnt, p_done_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cnt_main, cnt_p4;

   counters_ctl #(.NCH(NCH), .NREQ(NREQ), .W(W), .PRESC(1)) u_dut (
      .sysclk(clk), .foo_card_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_chan(req_chan), .req_turn(req_turn), .req_bar(req_bar), .req_err(req_err),
      .ch_baz(ch_baz), .ch_turn(ch_turn), .ch_bar(ch_bar), .ch_blrb(ch_blrb),
      .ch_zz1pb(ch_zz1pb), .ch_cwm(ch_cwm), .done_chan(done_chan), .done_req(done_req),
      .busy(busy)
`ifdef COUNTERS_CTL_STATS_EN
      , .done_cnt(done_cnt)
`endif
   );

   counters_ctl #(.NCH(NCH), .NREQ(NREQ), .W(W), .PRESC(4)) u_p4 (
      .sysclk(clk), .foo_card_n(rst_n), .req_valid(req_valid), .req_ready(p_req_ready),
      .req_chan(req_chan), .req_turn(req_turn), .req_bar(req_bar), .req_err(p_req_err),
      .ch_baz(p_ch_baz), .ch_turn(p_ch_turn), .ch_bar(p_ch_bar), .ch_blrb(p_ch_blrb),
      .ch_zz1pb(p_ch_zz1pb), .ch_cwm(ch_cwm), .done_chan(p_done_chan), .done_req(p_done_req),
      .busy(p_busy)
`ifdef COUNTERS_CTL_STATS_EN
      , .done_cnt(p_done_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_req(input int r, input logic v, input logic [2:0] ch,
                          input logic [31:0] t, input logic b);
      req_valid[r]        = v;
      req_chan[r*3 +: 3]  = ch;
      req_turn[r*W +: W]  = t;
      req_bar[r]          = b;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_chan  = '0;
      req_turn  = '0;
      req_bar   = '0;
      ch_cwm    = '0;

      // reset held
      smp(); smp();
      chk("rst_zz1pb", 32'(ch_zz1pb), 32'h1F);
      chk("rst_outs", 32'({ch_baz, ch_bar, ch_blrb, done_chan, busy, done_req, req_err, req_ready}), 0);
      chk("rst_turn", ch_turn, 0);
      chk("rst_p4_outs", 32'({p_ch_baz, p_ch_blrb, p_busy, p_req_err, p_ch_zz1pb}), 32'h1F);
      cyc(); rst_n = 1'b1;
      cyc(); cyc(); smp();
      chk("idle_outs", 32'({ch_baz, ch_blrb, done_chan, busy, req_err, ch_zz1pb}), 32'h1F);

      // one-shot on Z0
      cyc(); set_req(0, 1'b1, 3'(CH_Z0), 32'd3, MODE_ONESHOT);
      smp(); chk("os_ready", 32'(req_ready), 32'b0001);
      cyc(); set_req(0, 1'b0, 3'(CH_Z0), 32'd3, MODE_ONESHOT);
      smp();
      chk("os_baz", 32'(ch_baz), 32'b00001);
      chk("os_turn", ch_turn, 32'd3);
      chk("os_busy", 32'(busy), 32'b00001);
      chk("os_blrb", 32'(ch_blrb), 32'b00001);
      cyc(); smp(); chk("os_baz_one_cycle", 32'(ch_baz), 0);
      cyc(); ch_cwm[0] = 1'b1;
      smp(); chk("os_done_early", 32'(done_chan), 0);
      cyc(); smp();
      chk("os_done_chan", 32'(done_chan), 32'b00001);
      chk("os_done_req", 32'(done_req), 32'b0001);
      chk("os_zz1pb", 32'(ch_zz1pb), 32'b11110);
      chk("os_busy_free", 32'(busy), 0);
      cyc(); ch_cwm[0] = 1'b0;
      smp();
      chk("os_zz1pb_back", 32'(ch_zz1pb), 32'h1F);
      chk("os_done_gone", 32'(done_chan), 0);

      // contention on X2
      cyc(); set_req(1, 1'b1, 3'(CH_X2), 32'd5, MODE_ONESHOT);
             set_req(2, 1'b1, 3'(CH_X2), 32'd5, MODE_ONESHOT);
      smp(); chk("ct_ready_r1", 32'(req_ready), 32'b0010);
      cyc(); set_req(1, 1'b0, 3'(CH_X2), 32'd5, MODE_ONESHOT);
      smp();
      chk("ct_stall", 32'(req_ready), 0);
      chk("ct_busy", 32'(busy), 32'b00100);
      repeat (3) cyc();
      smp(); chk("ct_stall_hold", 32'(req_ready), 0);
      cyc(); ch_cwm[2] = 1'b1;
      cyc(); smp();
      chk("ct_done_req1", 32'(done_req), 32'b0010);
      chk("ct_ready_r2", 32'(req_ready), 32'b0100);
      cyc(); set_req(2, 1'b0, 3'(CH_X2), 32'd5, MODE_ONESHOT); ch_cwm[2] = 1'b0;
      smp();
      chk("ct_baz_r2", 32'(ch_baz), 32'b00100);
      chk("ct_busy_r2", 32'(busy), 32'b00100);
      cyc(); ch_cwm[2] = 1'b1;
      cyc(); smp(); chk("ct_done_req2", 32'(done_req), 32'b0100);
      cyc(); ch_cwm[2] = 1'b0;

      // periodic on DEBCT
      cyc(); set_req(3, 1'b1, 3'(CH_DEBCT), 32'd2, MODE_PERIODIC);
      smp(); chk("pd_ready", 32'(req_ready), 32'b1000);
      cyc(); set_req(3, 1'b0, 3'(CH_DEBCT), 32'd2, MODE_PERIODIC);
      smp(); chk("pd_bar", 32'(ch_bar), 32'b10000);
      for (int w = 0; w < 2; w++) begin
         cyc(); ch_cwm[4] = 1'b1;
         cyc(); smp();
         chk("pd_done_chan", 32'(done_chan), 32'b10000);
         chk("pd_done_req", 32'(done_req), 32'b1000);
         chk("pd_busy_held", 32'(busy), 32'b10000);
         cyc(); ch_cwm[4] = 1'b0;
      end

      // prescaler: 8 consecutive cycles with ch4 busy
      cnt_main = 0;
      cnt_p4   = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(); smp();
         if (ch_blrb[4])   cnt_main++;
         if (p_ch_blrb[4]) cnt_p4++;
      end
      chk("ps_main_blrb", 32'(cnt_main), 32'd8);
      chk("ps_p4_blrb", 32'(cnt_p4), 32'd2);

      // cwm rise on free W3: clear only
      cyc(); ch_cwm[3] = 1'b1;
      cyc(); smp();
      chk("fr_zz1pb", 32'(ch_zz1pb), 32'b10111);
      chk("fr_no_done", 32'(done_chan), 0);
      cyc(); ch_cwm[3] = 1'b0;

      // stop DEBCT
      cyc(); set_req(3, 1'b1, 3'(CH_DEBCT), 32'd0, MODE_PERIODIC);
      smp(); chk("st_ready", 32'(req_ready), 32'b1000);
      cyc(); set_req(3, 1'b0, 3'(CH_DEBCT), 32'd0, MODE_PERIODIC);
      smp();
      chk("st_baz", 32'(ch_baz), 32'b10000);
      chk("st_turn", ch_turn, 0);
      chk("st_busy", 32'(busy), 0);
      chk("st_blrb", 32'({ch_blrb, p_ch_blrb}), 0);

      // error path
      cyc(); set_req(0, 1'b1, 3'd6, 32'd7, MODE_ONESHOT);
      smp();
      chk("er_ready", 32'(req_ready), 32'b0001);
      chk("er_p4_ready", 32'(p_req_ready), 32'b0001);
      cyc(); set_req(0, 1'b0, 3'd6, 32'd7, MODE_ONESHOT);
      smp();
      chk("er_pulse", 32'({req_err, p_req_err}), 32'b11);
      chk("er_no_baz", 32'({ch_baz, busy}), 0);
      cyc(); smp(); chk("er_pulse_end", 32'(req_err), 0);

`ifdef COUNTERS_CTL_STATS_EN
      cyc(); set_req(0, 1'b1, 3'(CH_Y1), 32'd9, MODE_PERIODIC);
      cyc(); set_req(0, 1'b0, 3'(CH_Y1), 32'd9, MODE_PERIODIC);
      for (int w = 0; w < 3; w++) begin
         cyc(); ch_cwm[1] = 1'b1;
         cyc(); ch_cwm[1] = 1'b0;
      end
      cyc(); smp(); chk("sx_cnt3", 32'(done_cnt[31:16]), 32'd3);
      cyc(); set_req(0, 1'b1, 3'(CH_Y1), 32'd9, MODE_PERIODIC);
      cyc(); set_req(0, 1'b0, 3'(CH_Y1), 32'd9, MODE_PERIODIC);
      smp(); chk("sx_cnt_clr", 32'(done_cnt[31:16]), 0);
      cyc(); set_req(0, 1'b1, 3'(CH_Y1), 32'd0, MODE_PERIODIC);
      cyc(); set_req(0, 1'b0, 3'(CH_Y1), 32'd0, MODE_PERIODIC);
`endif

      // reset mid-run drops ownership
      cyc(); set_req(0, 1'b1, 3'(CH_Z0), 32'd4, MODE_PERIODIC);
      cyc(); set_req(0, 1'b0, 3'(CH_Z0), 32'd4, MODE_PERIODIC);
      smp(); chk("mr_busy_before", 32'(busy), 32'b00001);
      cyc(); rst_n = 1'b0;
      smp();
      chk("mr_busy_after", 32'({busy, ch_baz, ch_bar}), 0);
      chk("mr_zz1pb", 32'(ch_zz1pb), 32'h1F);
      cyc(); rst_n = 1'b1;
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
